// File: rtl/contador_bcd_adc_if.sv
// contador_bcd_adc_if -- bus between the ADC control FSM, the BCD
// timing/measurement counter and the display decoders.
// master: control side (drives en_0, reset, Vint_z).
// slave : counter side (drives en_3, bcd, resultado, valid, overrange).
interface contador_bcd_adc_if #(
   parameter int DIGITS = 3
);
   logic                en_0;
   logic                reset;
   logic                Vint_z;
   logic                en_3;
   logic [4*DIGITS-1:0] bcd;
   logic [4*DIGITS-1:0] resultado;
   logic                valid;
   logic                overrange;

   modport master (
      output en_0, reset, Vint_z,
      input  en_3, bcd, resultado, valid, overrange
   );

   modport slave (
      input  en_0, reset, Vint_z,
      output en_3, bcd, resultado, valid, overrange
   );
endinterface

// File: rtl/contador_bcd_adc.sv
// contador_bcd_adc -- run-up / run-down BCD counter for a dual-slope ADC.
// Counts a fixed 10^DIGITS-cycle integration period (end flagged on en_3),
// then counts de-integration until Vint_z and latches the count in resultado.
// Optional feature macro: ADC_OVERRANGE_EN (saturate at all 9s and raise the
// sticky overrange flag instead of wrapping during de-integration).
// Handshake: valid is a one-cycle, registered pulse marking the cycle in which
// resultado carries a new result; there is no ready/back-pressure, consumers
// must take resultado while it is stable (it holds until the next result).
module contador_bcd_adc #(
   parameter int DIGITS = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   contador_bcd_adc_if.slave bus,
   output logic [1:0]        state_dbg
);

   localparam int W = 4 * DIGITS;
   localparam logic [W-1:0] NINES = {DIGITS{4'h9}};

`ifdef ADC_OVERRANGE_EN
   localparam bit OVR_EN = 1'b1;
`else
   localparam bit OVR_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE = 2'd0, INTEG = 2'd1, DEINT = 2'd2, DONE = 2'd3} state_t;

   state_t         state, state_nxt;
   logic [W-1:0]   bcd_q, bcd_nxt;
   logic [W-1:0]   res_q, res_nxt;
   logic           en3_q, en3_nxt;
   logic           valid_q, valid_nxt;
   logic           ovr_q, ovr_nxt;
   logic           all_nines;

   // Decimal increment: each digit rolls 9->0 and carries into the next one.
   function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign all_nines = (bcd_q == NINES);

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic: reset and a dropped en_0 both force IDLE.
   always_comb begin
      state_nxt = state;
      if (bus.reset || !bus.en_0) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    state_nxt = INTEG;
            INTEG:   if (all_nines) state_nxt = DEINT;
            DEINT:   if (bus.Vint_z || (all_nines && OVR_EN)) state_nxt = DONE;
            default: state_nxt = state;
         endcase
      end
   end

   // Output/datapath next values; resultado and overrange survive aborts.
   always_comb begin
      bcd_nxt   = bcd_q;
      res_nxt   = res_q;
      en3_nxt   = 1'b0;
      valid_nxt = 1'b0;
      ovr_nxt   = ovr_q;
      if (bus.reset || !bus.en_0) begin
         bcd_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               bcd_nxt = '0;
               ovr_nxt = 1'b0;
            end
            INTEG: begin
               bcd_nxt = bcd_inc(bcd_q);
               en3_nxt = all_nines;
            end
            DEINT: begin
               if (bus.Vint_z) begin
                  res_nxt   = bcd_q;
                  valid_nxt = 1'b1;
               end else if (all_nines && OVR_EN) begin
                  res_nxt   = NINES;
                  ovr_nxt   = 1'b1;
                  valid_nxt = 1'b1;
               end else begin
                  bcd_nxt = bcd_inc(bcd_q);
               end
            end
            default: bcd_nxt = bcd_q;
         endcase
      end
   end

   // Output registers, so everything is stable at the FSM's falling-edge sample.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bcd_q   <= '0;
         res_q   <= '0;
         en3_q   <= 1'b0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         bcd_q   <= bcd_nxt;
         res_q   <= res_nxt;
         en3_q   <= en3_nxt;
         valid_q <= valid_nxt;
         ovr_q   <= ovr_nxt;
      end
   end

   assign bus.bcd       = bcd_q;
   assign bus.resultado = res_q;
   assign bus.en_3      = en3_q;
   assign bus.valid     = valid_q;
   assign bus.overrange = ovr_q;
   assign state_dbg     = state;

endmodule

// File: tb/tb_contador_bcd_adc.sv
// tb_contador_bcd_adc -- bench for contador_bcd_adc (DIGITS=3).
// Honours ADC_OVERRANGE_EN in its reference model when the macro is defined.
module tb_contador_bcd_adc;

   localparam int DIGITS = 3;
   localparam int W      = 4 * DIGITS;
   localparam int FULL   = 1000;

   logic       clk;
   logic       reset_n;
   logic [1:0] state_dbg;

   contador_bcd_adc_if #(.DIGITS(DIGITS)) bus ();

   contador_bcd_adc #(.DIGITS(DIGITS)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] exp_q[$];

   // reference model: phase of the conversion and plain integer counts
   int m_phase = 0;   // 0 idle, 1 integrating, 2 de-integrating, 3 done
   int m_cnt   = 0;
   int m_res   = 0;
   bit m_en3   = 0;
   bit m_valid = 0;
   bit m_ovr   = 0;

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      int           x;
      r = '0;
      x = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_phase = 0; m_cnt = 0; m_res = 0; m_en3 = 0; m_valid = 0; m_ovr = 0;
      end else begin
         m_en3   = 0;
         m_valid = 0;
         if (bus.reset || !bus.en_0) begin
            m_phase = 0;
            m_cnt   = 0;
         end else begin
            case (m_phase)
               0: begin m_phase = 1; m_cnt = 0; m_ovr = 0; end
               1: begin
                  m_cnt = (m_cnt + 1) % FULL;
                  if (m_cnt == 0) begin m_en3 = 1; m_phase = 2; end
               end
               2: begin
                  if (bus.Vint_z) begin
                     m_res = m_cnt; m_valid = 1; m_phase = 3;
                     exp_q.push_back(to_bcd(m_cnt));
                  end else if (m_cnt == FULL - 1) begin
`ifdef ADC_OVERRANGE_EN
                     m_res = FULL - 1; m_ovr = 1; m_valid = 1; m_phase = 3;
                     exp_q.push_back(to_bcd(FULL - 1));
`else
                     m_cnt = 0;
`endif
                  end else begin
                     m_cnt = m_cnt + 1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // scoreboard: compare every cycle on the falling edge
   always @(negedge clk) begin
      check("bcd",       bus.bcd,       to_bcd(m_cnt));
      check("resultado", bus.resultado, to_bcd(m_res));
      check("en_3",      W'(bus.en_3),      W'(m_en3));
      check("valid",     W'(bus.valid),     W'(m_valid));
      check("overrange", W'(bus.overrange), W'(m_ovr));
      if (bus.valid === 1'b1) begin
         if (exp_q.size() == 0) check("valid_without_result", W'(1), W'(0));
         else check("result_queue", bus.resultado, exp_q.pop_front());
      end
   end

   // driver tasks
   task automatic start_conv();
      bus.en_0 = 1'b0;
      @(negedge clk);
      bus.en_0 = 1'b1;
   endtask

   task automatic wait_bcd(input logic [W-1:0] v, input int budget);
      int n = 0;
      while (bus.bcd !== v && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (bus.bcd !== v) check("wait_bcd_timeout", bus.bcd, v);
   endtask

   task automatic wait_en3(input bit rand_vz, output int n);
      n = 0;
      do begin
         if (rand_vz) bus.Vint_z = 1'($urandom_range(0, 1));
         @(negedge clk);
         n++;
      end while (bus.en_3 !== 1'b1 && n < 2100);
      bus.Vint_z = 1'b0;
      if (bus.en_3 !== 1'b1) check("wait_en3_timeout", W'(bus.en_3), W'(1));
   endtask

   task automatic pulse_vz();
      bus.Vint_z = 1'b1;
      @(negedge clk);
      bus.Vint_z = 1'b0;
   endtask

   logic [W-1:0] last_res;
   int           n;
   int           k;
   int           n_wait;

   initial begin
      reset_n    = 1'b1;
      bus.en_0   = 1'b0;
      bus.reset  = 1'b0;
      bus.Vint_z = 1'b0;
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_bcd",       bus.bcd,       12'h000);
      check("rst_resultado", bus.resultado, 12'h000);
      check("rst_valid",     W'(bus.valid), W'(0));
      reset_n = 1'b1;
      @(negedge clk);

      // nominal conversion: en_3 timing, latch at 0x437
      start_conv();
      wait_en3(1'b0, n);
      check("en_3_latency", W'(n), W'(1001));
      check("deint_first_bcd", bus.bcd, 12'h000);
      wait_bcd(12'h437, 600);
      pulse_vz();
      check("nominal_resultado", bus.resultado, 12'h437);
      check("nominal_valid", W'(bus.valid), W'(1));
      @(negedge clk);
      check("nominal_valid_drop", W'(bus.valid), W'(0));
      check("done_bcd_hold", bus.bcd, 12'h437);

      // carry chain through INTEG, then latch exactly at 0x999
      start_conv();
      wait_bcd(12'h009, 50);
      @(negedge clk);
      check("carry_009", bus.bcd, 12'h010);
      wait_bcd(12'h099, 200);
      @(negedge clk);
      check("carry_099", bus.bcd, 12'h100);
      wait_bcd(12'h999, 1000);
      @(negedge clk);
      check("carry_999", bus.bcd, 12'h000);
      check("carry_999_en3", W'(bus.en_3), W'(1));
      wait_bcd(12'h999, 1100);
      pulse_vz();
      check("boundary_resultado", bus.resultado, 12'h999);
      check("boundary_overrange", W'(bus.overrange), W'(0));

      // over full scale
      start_conv();
      wait_en3(1'b0, n);
`ifdef ADC_OVERRANGE_EN
      n_wait = 0;
      while (bus.valid !== 1'b1 && n_wait < 1100) begin
         @(negedge clk);
         n_wait++;
      end
      check("ovr_resultado", bus.resultado, 12'h999);
      check("ovr_flag", W'(bus.overrange), W'(1));
      last_res = 12'h999;
`else
      wait_bcd(12'h999, 1100);
      wait_bcd(12'h012, 50);
      pulse_vz();
      check("wrap_resultado", bus.resultado, 12'h012);
      check("wrap_overrange", W'(bus.overrange), W'(0));
      last_res = 12'h012;
`endif

      // abort by synchronous reset at 0x500 during INTEG
      start_conv();
      wait_bcd(12'h500, 600);
      bus.reset = 1'b1;
      @(negedge clk);
      check("abort_reset_bcd", bus.bcd, 12'h000);
      check("abort_reset_en3", W'(bus.en_3), W'(0));
      check("abort_reset_res", bus.resultado, last_res);
      bus.reset = 1'b0;

      // abort by dropping en_0 mid-DEINT (conversion restarted after reset)
      wait_en3(1'b0, n);
      wait_bcd(12'h250, 300);
      bus.en_0 = 1'b0;
      @(negedge clk);
      check("abort_en0_bcd", bus.bcd, 12'h000);
      check("abort_en0_valid", W'(bus.valid), W'(0));
      check("abort_en0_res", bus.resultado, last_res);

      // randomized conversions, aborts and stray Vint_z during INTEG
      for (int it = 0; it < 6; it++) begin
         start_conv();
         wait_en3(1'b1, n);
         k = $urandom_range(0, 1199);
         repeat (k) @(negedge clk);
         if ($urandom_range(0, 5) == 0) bus.en_0 = 1'b0;
         else pulse_vz();
         repeat (3) @(negedge clk);
      end

      // asynchronous reset in the middle of DEINT
      start_conv();
      wait_en3(1'b0, n);
      wait_bcd(12'h100, 200);
      #2 reset_n = 1'b0;
      #1;
      check("async_bcd",       bus.bcd,       12'h000);
      check("async_resultado", bus.resultado, 12'h000);
      check("async_en3",       W'(bus.en_3),      W'(0));
      check("async_valid",     W'(bus.valid),     W'(0));
      check("async_overrange", W'(bus.overrange), W'(0));
      bus.en_0 = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("post_reset_bcd", bus.bcd, 12'h000);
      check("post_reset_queue", W'(exp_q.size()), W'(0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
